branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-side next-PC predictor for the 5-stage pipelined processor.
- Feeds the imem address mux and is trained by branch resolution in the execute stage.
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Also keeps branch and mispredict counters that are exposed as debug outputs next to the existing cycles/inst outputs.

Parameters:
PC_WIDTH, 12, width of the word-addressed imem address
INDEX_BITS, 6, BTB index width; ENTRIES = 2**INDEX_BITS = 64
TAG_BITS, PC_WIDTH-INDEX_BITS (6), tag width

Ports:
clock  input  1  master clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
fetch_pc  input  PC_WIDTH  PC currently presented to imem
predict_taken  output  1  prediction for fetch_pc (combinational)
predict_target  output  PC_WIDTH  predicted next PC (combinational)
update_valid  input  1  execute stage resolved a branch/jump this cycle
update_pc  input  PC_WIDTH  PC of the resolved instruction
update_taken  input  1  actual outcome
update_target  input  PC_WIDTH  actual taken target
update_pred_taken  input  1  prediction carried down the pipe for that instruction
update_pred_target  input  PC_WIDTH  predicted target carried down the pipe
bp_clear  input  1  synchronous invalidate of all entries
mispredict  output  1  registered; 1-cycle pulse the cycle after a mispredicted update
branch_count  output  32  number of accepted updates
mispredict_count  output  32  number of mispredicted updates

Behaviour:
- Index = pc[INDEX_BITS-1:0]; tag = pc[PC_WIDTH-1:INDEX_BITS].
- Each entry holds valid, tag[TAG_BITS], target[PC_WIDTH] and ctr[2].
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx] == fetch_tag.
  - predict_taken = hit && ctr[idx][1].
  - predict_target = predict_taken ? target[idx] : fetch_pc+1, wrapping modulo 2**PC_WIDTH (0xFFF+1 = 0x000).
- Update (on clock edge when update_valid = 1):
  - Entry hit at update_pc: ctr increments when taken and decrements when not taken, saturating at 11 and 00. When taken, target <= update_target.
  - Miss and taken: allocate the entry. valid <= 1, tag and target written, ctr <= 10 (weakly taken). Any existing entry is overwritten with no replacement choice.
  - Miss and not taken: no table change.
- Mispredict:
  - mp = update_valid && (update_pred_taken != update_taken || (update_taken && update_pred_target != update_target)).
  - mispredict <= mp, so it is high for exactly the one cycle after the update.
- Counters:
  - branch_count += update_valid.
  - mispredict_count += mp.
  - Both are 32-bit and wrap at 2**32.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. There is no write-through bypass; the new value is visible on the next cycle.
- bp_clear:
  - Clears all valid bits and sets every ctr to 01 on the next edge.
  - Statistics counters are not affected.
  - If update_valid is also asserted in that cycle, bp_clear wins and no allocation occurs. Counters still count the update.
- Reset (asynchronous, active-low, takes effect immediately, including mid-update):
  - All valid bits = 0, all ctr = 01, mispredict = 0, branch_count = 0, mispredict_count = 0.
  - Tag and target contents are don't-care.
  - Outputs during reset: predict_taken = 0, predict_target = fetch_pc+1.
- Storage is implemented in flops, not syncram, because lookup is asynchronous-read.

Decomposition:
- Shared package holds:
  - Counter encodings: SNT = 00, WNT = 01, WT = 10, ST = 11.
  - The default PC_WIDTH and INDEX_BITS.
  - The btb_entry struct typedef (valid, tag, target, ctr).
- One natural sub-module, sat_counter2: a 2-bit saturating up/down counter with an enable. The top instantiates one per entry, or uses it as a next-state function.

Test Plan:
- Reset then lookup fetch_pc=0x010 -> predict_taken=0, predict_target=0x011; both stats counters read 0.
- Update pc=0x010, taken, target=0x080 (pred 0/0x011) -> mispredict pulses 1 cycle later. Next-cycle lookup of 0x010 gives taken with target 0x080. branch_count=1, mispredict_count=1.
- Aliasing: after the above, look up pc=0x050 (same index 0x10, different tag) -> not taken, target 0x051. Update 0x050 taken to 0x200 -> entry replaced, and 0x010 now misses.
- Saturation: starting from ctr=10, apply 3 not-taken updates to 0x010 -> taken, then not taken, then not taken. Two taken updates then return ctr to 10 (taken).
- Wrap and same-cycle: fetch_pc=0xFFF cold -> target 0x000. Update and look up 0x020 in the same cycle -> lookup sees the old miss, and the following cycle sees the hit.
- Clear and async reset: assert bp_clear with update_valid -> all entries miss next cycle and branch_count still increments. Drop reset mid-cycle -> outputs and counters clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the fetch-side BTB predictor.
// Counter encodings, default geometry and the BTB entry layout.
package branch_predictor_pkg;

  localparam int PC_WIDTH_DEF   = 12;
  localparam int INDEX_BITS_DEF = 6;
  localparam int TAG_BITS_DEF   = PC_WIDTH_DEF - INDEX_BITS_DEF;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                    valid;
    logic [TAG_BITS_DEF-1:0] tag;
    logic [PC_WIDTH_DEF-1:0] target;
    ctr_e                    ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, used as a next-state function.
// Holds when disabled; saturates at ST going up and SNT going down.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic en_i,
  input  logic up_i,
  input  ctr_e ctr_i,
  output ctr_e ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (en_i) begin
      if (up_i && ctr_i != ST)
        ctr_o = ctr_e'(ctr_i + 2'd1);
      else if (!up_i && ctr_i != SNT)
        ctr_o = ctr_e'(ctr_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB next-PC predictor with 2-bit direction counters.
// Asynchronous-read lookup; trained by execute-stage branch resolution.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PC_WIDTH   = PC_WIDTH_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic                predict_taken,
  output logic [PC_WIDTH-1:0] predict_target,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic                update_taken,
  input  logic [PC_WIDTH-1:0] update_target,
  input  logic                update_pred_taken,
  input  logic [PC_WIDTH-1:0] update_pred_target,
  input  logic                bp_clear,
  output logic                mispredict,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  localparam int TAG_BITS = PC_WIDTH - INDEX_BITS;
  localparam int ENTRIES  = 2 ** INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  ctr_e                ctr_q [ENTRIES];
  ctr_e                ctr_d [ENTRIES];
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];

  logic        mp_q, mp_d;
  logic [31:0] bc_q, bc_d;
  logic [31:0] mc_q, mc_d;

  logic [INDEX_BITS-1:0] fidx, uidx;
  logic [TAG_BITS-1:0]   ftag, utag;
  logic                  fhit, uhit, mp;
  ctr_e                  ctr_upd;

  assign fidx = fetch_pc[INDEX_BITS-1:0];
  assign ftag = fetch_pc[PC_WIDTH-1:INDEX_BITS];
  assign uidx = update_pc[INDEX_BITS-1:0];
  assign utag = update_pc[PC_WIDTH-1:INDEX_BITS];

  assign fhit = valid_q[fidx] && (tag_q[fidx] == ftag);
  assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

  assign predict_taken  = fhit && ctr_q[fidx][1];
  assign predict_target = predict_taken ? target_q[fidx]
                                        : fetch_pc + PC_WIDTH'(1);

  assign mp = update_valid &&
              ((update_pred_taken != update_taken) ||
               (update_taken &&
                update_pred_target != update_target));

  sat_counter2 u_ctr (
    .en_i  (uhit),
    .up_i  (update_taken),
    .ctr_i (ctr_q[uidx]),
    .ctr_o (ctr_upd)
  );

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    if (bp_clear) begin
      valid_d = '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_d[i] = WNT;
    end else if (update_valid) begin
      if (uhit) begin
        ctr_d[uidx] = ctr_upd;
      end else if (update_taken) begin
        valid_d[uidx] = 1'b1;
        ctr_d[uidx]   = WT;
      end
    end
    mp_d = mp;
    bc_d = bc_q + 32'(update_valid);
    mc_d = mc_q + 32'(mp);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= WNT;
      mp_q <= 1'b0;
      bc_q <= '0;
      mc_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      mp_q    <= mp_d;
      bc_q    <= bc_d;
      mc_q    <= mc_d;
    end
  end

  // Tag/target need no reset: they are only read behind a valid bit.
  always_ff @(posedge clock) begin
    if (update_valid && update_taken && !bp_clear) begin
      tag_q[uidx]    <= utag;
      target_q[uidx] <= update_target;
    end
  end

  assign mispredict       = mp_q;
  assign branch_count     = bc_q;
  assign mispredict_count = mc_q;

endmodule
